// File: rtl/control_pipe_pkg.sv
// Shared constants for the pipelined control decoder: widths, group codes, opcodes, mem/jump ops.
package control_pipe_pkg;

    localparam int unsigned OP_CODE_BITS_DEF = 6;
    localparam int unsigned ALU_OP_BITS_DEF  = 6;
    localparam int unsigned MEM_OP_BITS_DEF  = 2;
    localparam int unsigned JUMP_BITS_DEF    = 4;
    localparam int unsigned REG_BITS_DEF     = 5;
    localparam int unsigned GROUP_BITS       = 2;
    localparam int unsigned FIFO_DEPTH       = 2;

    // Opcode groups, taken from the two most significant opcode bits
    localparam logic [1:0] GRP_RTYPE = 2'b00;
    localparam logic [1:0] GRP_ITYPE = 2'b01;
    localparam logic [1:0] GRP_MEM   = 2'b10;
    localparam logic [1:0] GRP_JUMP  = 2'b11;

    localparam logic [1:0] MEM_OP_NOP   = 2'd0;
    localparam logic [1:0] MEM_OP_READ  = 2'd1;
    localparam logic [1:0] MEM_OP_WRITE = 2'd2;

    localparam logic [3:0] JMP_OP_NOP = 4'd0;

    localparam logic [5:0] OP_CODE_ADD  = 6'b000000;
    localparam logic [5:0] OP_CODE_ADDI = 6'b010000;
    localparam logic [5:0] OP_CODE_LW   = 6'b100000;
    localparam logic [5:0] OP_CODE_SW   = 6'b100001;
    localparam logic [5:0] OP_CODE_LA   = 6'b100010;
    localparam logic [5:0] OP_CODE_SA   = 6'b100011;

endpackage

// File: rtl/control_pipe_decode.sv
// Pure combinational opcode -> datapath control bundle decoder.
module control_decode
    import control_pipe_pkg::*;
#(
    parameter int unsigned OP_CODE_BITS = OP_CODE_BITS_DEF,
    parameter int unsigned ALU_OP_BITS  = ALU_OP_BITS_DEF,
    parameter int unsigned MEM_OP_BITS  = MEM_OP_BITS_DEF,
    parameter int unsigned JUMP_BITS    = JUMP_BITS_DEF,
    parameter int unsigned REG_BITS     = REG_BITS_DEF
) (
    input  logic [OP_CODE_BITS-1:0] i_opcode,
    input  logic [REG_BITS-1:0]     i_rt,
    input  logic [REG_BITS-1:0]     i_rd,
    output logic                    o_reg_dst,
    output logic                    o_alu_src,
    output logic                    o_mem_to_reg,
    output logic                    o_reg_write,
    output logic                    o_address_src,
    output logic [ALU_OP_BITS-1:0]  o_alu_op,
    output logic [MEM_OP_BITS-1:0]  o_mem_op,
    output logic [JUMP_BITS-1:0]    o_jop,
    output logic [REG_BITS-1:0]     o_wreg,
    output logic                    o_illegal
);

    logic [GROUP_BITS-1:0] w_group;

    assign w_group = i_opcode[OP_CODE_BITS-1 -: GROUP_BITS];

    // Group-based decode; anything not explicitly set stays 0 / NOP
    always_comb begin
        o_reg_dst     = 1'b0;
        o_alu_src     = 1'b0;
        o_mem_to_reg  = 1'b0;
        o_reg_write   = 1'b0;
        o_address_src = 1'b0;
        o_alu_op      = '0;
        o_mem_op      = MEM_OP_BITS'(MEM_OP_NOP);
        o_jop         = JUMP_BITS'(JMP_OP_NOP);
        o_illegal     = 1'b0;
        case (w_group)
            GRP_RTYPE: begin
                o_reg_dst   = 1'b1;
                o_reg_write = 1'b1;
                o_alu_op    = ALU_OP_BITS'(i_opcode);
            end
            GRP_ITYPE: begin
                o_alu_src   = 1'b1;
                o_reg_write = 1'b1;
                o_alu_op    = ALU_OP_BITS'(i_opcode[3:0]);
            end
            GRP_MEM: begin
                if (i_opcode[3:2] != 2'b00) begin
                    o_illegal = 1'b1;
                end else begin
                    o_address_src = i_opcode[1];
                    if (!i_opcode[0]) begin
                        o_mem_op     = MEM_OP_BITS'(MEM_OP_READ);
                        o_mem_to_reg = 1'b1;
                        o_reg_write  = 1'b1;
                    end else begin
                        o_mem_op = MEM_OP_BITS'(MEM_OP_WRITE);
                    end
                end
            end
            GRP_JUMP: begin
                o_jop = JUMP_BITS'(i_opcode[3:0]);
            end
        endcase
        o_wreg = o_reg_dst ? i_rd : i_rt;
    end

endmodule

// File: rtl/control_pipe.sv
// Pipelined control decoder: decode into a 2-entry FIFO with load-use bubble insertion and flush.
module control_pipe
    import control_pipe_pkg::*;
#(
    parameter int unsigned OP_CODE_BITS = OP_CODE_BITS_DEF,
    parameter int unsigned ALU_OP_BITS  = ALU_OP_BITS_DEF,
    parameter int unsigned MEM_OP_BITS  = MEM_OP_BITS_DEF,
    parameter int unsigned JUMP_BITS    = JUMP_BITS_DEF,
    parameter int unsigned REG_BITS     = REG_BITS_DEF,
    parameter bit          HAZARD_EN    = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OP_CODE_BITS-1:0] in_opcode,
    input  logic [REG_BITS-1:0]     in_rs,
    input  logic [REG_BITS-1:0]     in_rt,
    input  logic [REG_BITS-1:0]     in_rd,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_reg_dst,
    output logic                    out_alu_src,
    output logic                    out_mem_to_reg,
    output logic                    out_reg_write,
    output logic                    out_address_src,
    output logic [ALU_OP_BITS-1:0]  out_alu_op,
    output logic [MEM_OP_BITS-1:0]  out_mem_op,
    output logic [JUMP_BITS-1:0]    out_jop,
    output logic [REG_BITS-1:0]     out_wreg,
    output logic                    out_bubble,
    output logic                    out_illegal
);

    // Entry layout: {5 control bits, alu_op, mem_op, jop, wreg, bubble, illegal}
    localparam int unsigned ENTRY_W = 5 + ALU_OP_BITS + MEM_OP_BITS + JUMP_BITS + REG_BITS + 2;

    logic [ENTRY_W-1:0]     r_mem [FIFO_DEPTH];
    logic                   r_wptr;
    logic                   r_rptr;
    logic [1:0]             r_count;
    logic                   r_ld_valid;
    logic [REG_BITS-1:0]    r_ld_reg;

    logic                   w_dec_reg_dst;
    logic                   w_dec_alu_src;
    logic                   w_dec_mem_to_reg;
    logic                   w_dec_reg_write;
    logic                   w_dec_address_src;
    logic [ALU_OP_BITS-1:0] w_dec_alu_op;
    logic [MEM_OP_BITS-1:0] w_dec_mem_op;
    logic [JUMP_BITS-1:0]   w_dec_jop;
    logic [REG_BITS-1:0]    w_dec_wreg;
    logic                   w_dec_illegal;
    logic [ENTRY_W-1:0]     w_dec_entry;
    logic [ENTRY_W-1:0]     w_wr_entry;
    logic [ENTRY_W-1:0]     w_head;
    logic                   w_full;
    logic                   w_hazard;
    logic                   w_push_in;
    logic                   w_push_bub;
    logic                   w_push;
    logic                   w_pop;

    control_decode #(
        .OP_CODE_BITS (OP_CODE_BITS),
        .ALU_OP_BITS  (ALU_OP_BITS),
        .MEM_OP_BITS  (MEM_OP_BITS),
        .JUMP_BITS    (JUMP_BITS),
        .REG_BITS     (REG_BITS)
    ) u_decode (
        .i_opcode      (in_opcode),
        .i_rt          (in_rt),
        .i_rd          (in_rd),
        .o_reg_dst     (w_dec_reg_dst),
        .o_alu_src     (w_dec_alu_src),
        .o_mem_to_reg  (w_dec_mem_to_reg),
        .o_reg_write   (w_dec_reg_write),
        .o_address_src (w_dec_address_src),
        .o_alu_op      (w_dec_alu_op),
        .o_mem_op      (w_dec_mem_op),
        .o_jop         (w_dec_jop),
        .o_wreg        (w_dec_wreg),
        .o_illegal     (w_dec_illegal)
    );

    assign w_dec_entry = {w_dec_reg_dst, w_dec_alu_src, w_dec_mem_to_reg, w_dec_reg_write,
                          w_dec_address_src, w_dec_alu_op, w_dec_mem_op, w_dec_jop,
                          w_dec_wreg, 1'b0, w_dec_illegal};

    // Handshake and interlock: a hazard blocks the input and, if there is room, enqueues a bubble
    assign w_full     = (r_count == 2'd2);
    assign w_hazard   = HAZARD_EN && r_ld_valid && in_valid &&
                        ((in_rs == r_ld_reg) || (in_rt == r_ld_reg));
    assign in_ready   = !reset && !w_full && !w_hazard && !flush;
    assign w_push_in  = in_valid && in_ready;
    assign w_push_bub = w_hazard && !w_full && !flush && !reset;
    assign w_push     = w_push_in || w_push_bub;
    assign out_valid  = (r_count != 2'd0);
    assign w_pop      = out_valid && out_ready && !flush;
    assign w_wr_entry = w_push_bub ? ENTRY_W'(2) : w_dec_entry;

    // Head entry drives the outputs; an empty FIFO presents all zeros
    assign w_head = out_valid ? r_mem[r_rptr] : '0;
    assign {out_reg_dst, out_alu_src, out_mem_to_reg, out_reg_write, out_address_src,
            out_alu_op, out_mem_op, out_jop, out_wreg, out_bubble, out_illegal} = w_head;

    // FIFO storage, pointers, occupancy and load tracker; flush behaves like reset
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_count    <= 2'd0;
            r_ld_valid <= 1'b0;
            r_ld_reg   <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_wr_entry;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_push_in) begin
                r_ld_valid <= HAZARD_EN && (w_dec_mem_op == MEM_OP_BITS'(MEM_OP_READ));
                r_ld_reg   <= w_dec_wreg;
            end else if (w_push_bub) begin
                r_ld_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_control_pipe.sv
// Bench for control_pipe: scoreboard of expected head entries plus a small hazard/occupancy model.
module tb_control_pipe;
    import control_pipe_pkg::*;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       address_src;
        logic [5:0] alu_op;
        logic [1:0] mem_op;
        logic [3:0] jop;
        logic [4:0] wreg;
        logic       bubble;
        logic       illegal;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       flush, in_valid, in_ready, out_valid, out_ready;
    logic [5:0] in_opcode;
    logic [4:0] in_rs, in_rt, in_rd;
    logic       o_reg_dst, o_alu_src, o_mem_to_reg, o_reg_write, o_address_src, o_bubble, o_illegal;
    logic [5:0] o_alu_op;
    logic [1:0] o_mem_op;
    logic [3:0] o_jop;
    logic [4:0] o_wreg;

    logic       n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic [5:0] n_opcode;
    logic [4:0] n_rs, n_rt, n_rd;
    logic       n_reg_dst, n_alu_src, n_mem_to_reg, n_reg_write, n_address_src, n_bubble, n_illegal;
    logic [5:0] n_alu_op;
    logic [1:0] n_mem_op;
    logic [3:0] n_jop;
    logic [4:0] n_wreg;

    exp_t w_obs_h, w_obs_n;
    exp_t q[$];
    logic       m_ld;
    logic [4:0] m_ldreg;
    int n_pass = 0, n_fail = 0, n_total = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    control_pipe #(.HAZARD_EN(1'b1)) dut_h (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_reg_dst(o_reg_dst), .out_alu_src(o_alu_src), .out_mem_to_reg(o_mem_to_reg),
        .out_reg_write(o_reg_write), .out_address_src(o_address_src), .out_alu_op(o_alu_op),
        .out_mem_op(o_mem_op), .out_jop(o_jop), .out_wreg(o_wreg),
        .out_bubble(o_bubble), .out_illegal(o_illegal)
    );

    control_pipe #(.HAZARD_EN(1'b0)) dut_n (
        .clk(clk), .reset(reset), .flush(n_flush), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .in_opcode(n_opcode), .in_rs(n_rs), .in_rt(n_rt), .in_rd(n_rd),
        .out_valid(n_out_valid), .out_ready(n_out_ready),
        .out_reg_dst(n_reg_dst), .out_alu_src(n_alu_src), .out_mem_to_reg(n_mem_to_reg),
        .out_reg_write(n_reg_write), .out_address_src(n_address_src), .out_alu_op(n_alu_op),
        .out_mem_op(n_mem_op), .out_jop(n_jop), .out_wreg(n_wreg),
        .out_bubble(n_bubble), .out_illegal(n_illegal)
    );

    assign w_obs_h = {o_reg_dst, o_alu_src, o_mem_to_reg, o_reg_write, o_address_src,
                      o_alu_op, o_mem_op, o_jop, o_wreg, o_bubble, o_illegal};
    assign w_obs_n = {n_reg_dst, n_alu_src, n_mem_to_reg, n_reg_write, n_address_src,
                      n_alu_op, n_mem_op, n_jop, n_wreg, n_bubble, n_illegal};

    // Reference decode written from the opcode table
    function automatic exp_t exp_dec(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd);
        exp_t e;
        e = '0;
        case (op[5:4])
            2'b00: begin e.reg_dst = 1'b1; e.reg_write = 1'b1; e.alu_op = op; end
            2'b01: begin e.alu_src = 1'b1; e.reg_write = 1'b1; e.alu_op = {2'b00, op[3:0]}; end
            2'b10: begin
                if (op[3:2] != 2'b00) begin
                    e.illegal = 1'b1;
                end else begin
                    e.address_src = op[1];
                    if (op[0]) begin
                        e.mem_op = 2'd2;
                    end else begin
                        e.mem_op = 2'd1; e.mem_to_reg = 1'b1; e.reg_write = 1'b1;
                    end
                end
            end
            default: e.jop = op[3:0];
        endcase
        e.wreg = e.reg_dst ? rd : rt;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus for dut_h: drive, compare against the model, update the model, advance
    task automatic cyc(input string tag, input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic ordy, input logic fl);
        logic exp_full, exp_haz, exp_rdy;
        exp_t bub;
        in_valid = v; in_opcode = op; in_rs = rs; in_rt = rt; in_rd = rd;
        out_ready = ordy; flush = fl;
        #1;
        exp_full = (q.size() == 2);
        exp_haz  = m_ld && v && ((rs == m_ldreg) || (rt == m_ldreg));
        exp_rdy  = !exp_full && !exp_haz && !fl;
        check($sformatf("%s.in_ready", tag), 32'(in_ready), 32'(exp_rdy));
        check($sformatf("%s.out_valid", tag), 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) check($sformatf("%s.head", tag), 32'(w_obs_h), 32'(q[0]));
        if (fl) begin
            q.delete();
            m_ld = 1'b0;
        end else begin
            if (q.size() != 0 && ordy) void'(q.pop_front());
            if (v && exp_rdy) begin
                q.push_back(exp_dec(op, rt, rd));
                m_ld    = (op[5:4] == 2'b10) && (op[3:2] == 2'b00) && !op[0];
                m_ldreg = rt;
            end else if (exp_haz && !exp_full) begin
                bub = '0;
                bub.bubble = 1'b1;
                q.push_back(bub);
                m_ld = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_opcode = '0;
        in_rs = '0; in_rt = '0; in_rd = '0; out_ready = 1'b1;
        n_flush = 1'b0; n_in_valid = 1'b0; n_opcode = '0;
        n_rs = '0; n_rt = '0; n_rd = '0; n_out_ready = 1'b1;
        m_ld = 1'b0; m_ldreg = '0;

        // Reset held for two cycles
        repeat (2) @(posedge clk);
        #1;
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.outs", 32'(w_obs_h), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;

        // Basic decode and one-cycle latency
        cyc("idle",  1'b0, OP_CODE_ADD,  5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        cyc("add",   1'b1, OP_CODE_ADD,  5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        cyc("addi",  1'b1, OP_CODE_ADDI, 5'd1, 5'd5, 5'd3, 1'b1, 1'b0);
        cyc("r7",    1'b1, 6'b000111,    5'd2, 5'd6, 5'd9, 1'b1, 1'b0);
        cyc("drn1",  1'b0, OP_CODE_ADD,  5'd0, 5'd0, 5'd0, 1'b1, 1'b0);

        // Load-use bubble
        cyc("lw",    1'b1, OP_CODE_LW,   5'd1, 5'd4, 5'd0, 1'b1, 1'b0);
        cyc("haz",   1'b1, OP_CODE_ADD,  5'd4, 5'd2, 5'd7, 1'b1, 1'b0);
        cyc("haz2",  1'b1, OP_CODE_ADD,  5'd4, 5'd2, 5'd7, 1'b1, 1'b0);
        cyc("drn2",  1'b0, OP_CODE_ADD,  5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        cyc("drn3",  1'b0, OP_CODE_ADD,  5'd0, 5'd0, 5'd0, 1'b1, 1'b0);

        // Back-pressure: fill, stall, dequeue while full, then accept
        cyc("bp1",   1'b1, 6'b010001,    5'd1, 5'd1, 5'd0, 1'b0, 1'b0);
        cyc("bp2",   1'b1, 6'b010010,    5'd2, 5'd2, 5'd0, 1'b0, 1'b0);
        cyc("bp3",   1'b1, 6'b010011,    5'd3, 5'd3, 5'd0, 1'b0, 1'b0);
        cyc("bp4",   1'b1, 6'b010011,    5'd3, 5'd3, 5'd0, 1'b1, 1'b0);
        cyc("bp5",   1'b1, 6'b010011,    5'd3, 5'd3, 5'd0, 1'b0, 1'b0);
        cyc("bp6",   1'b0, OP_CODE_ADD,  5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        cyc("bp7",   1'b0, OP_CODE_ADD,  5'd0, 5'd0, 5'd0, 1'b1, 1'b0);

        // Hazard seen while full: bubble deferred until space frees
        cyc("hf1",   1'b1, OP_CODE_ADD,  5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        cyc("hf2",   1'b1, OP_CODE_LW,   5'd1, 5'd9, 5'd0, 1'b0, 1'b0);
        cyc("hf3",   1'b1, OP_CODE_ADD,  5'd9, 5'd2, 5'd4, 1'b0, 1'b0);
        cyc("hf4",   1'b1, OP_CODE_ADD,  5'd9, 5'd2, 5'd4, 1'b1, 1'b0);
        cyc("hf5",   1'b1, OP_CODE_ADD,  5'd9, 5'd2, 5'd4, 1'b1, 1'b0);
        cyc("hf6",   1'b1, OP_CODE_ADD,  5'd9, 5'd2, 5'd4, 1'b1, 1'b0);
        cyc("hf7",   1'b0, OP_CODE_ADD,  5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        cyc("hf8",   1'b0, OP_CODE_ADD,  5'd0, 5'd0, 5'd0, 1'b1, 1'b0);

        // Flush with two entries held; the pending load no longer interlocks
        cyc("fl1",   1'b1, OP_CODE_ADD,  5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        cyc("fl2",   1'b1, OP_CODE_LW,   5'd1, 5'd6, 5'd0, 1'b0, 1'b0);
        cyc("fl3",   1'b1, OP_CODE_ADD,  5'd6, 5'd6, 5'd5, 1'b0, 1'b1);
        cyc("fl4",   1'b1, OP_CODE_ADD,  5'd6, 5'd6, 5'd5, 1'b1, 1'b0);
        cyc("fl5",   1'b0, OP_CODE_ADD,  5'd0, 5'd0, 5'd0, 1'b1, 1'b0);

        // Illegal, store, address-select load, jump
        cyc("ill",   1'b1, 6'b100100,    5'd1, 5'd3, 5'd2, 1'b1, 1'b0);
        cyc("sw",    1'b1, OP_CODE_SW,   5'd1, 5'd3, 5'd2, 1'b1, 1'b0);
        cyc("la",    1'b1, OP_CODE_LA,   5'd1, 5'd8, 5'd2, 1'b1, 1'b0);
        cyc("jmp",   1'b1, 6'b110101,    5'd2, 5'd3, 5'd4, 1'b1, 1'b0);
        cyc("sa",    1'b1, OP_CODE_SA,   5'd2, 5'd3, 5'd4, 1'b1, 1'b0);
        cyc("drn4",  1'b0, OP_CODE_ADD,  5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        cyc("drn5",  1'b0, OP_CODE_ADD,  5'd0, 5'd0, 5'd0, 1'b1, 1'b0);

        // Interlock disabled: load then dependent add flow through without a bubble
        n_in_valid = 1'b1; n_opcode = OP_CODE_LW; n_rs = 5'd1; n_rt = 5'd4; n_rd = 5'd0;
        #1;
        check("nohaz.lw_ready", 32'(n_in_ready), 32'd1);
        @(posedge clk);
        #1;
        n_opcode = OP_CODE_ADD; n_rs = 5'd4; n_rt = 5'd2; n_rd = 5'd7;
        #1;
        check("nohaz.add_ready", 32'(n_in_ready), 32'd1);
        check("nohaz.lw_head", 32'(w_obs_n), 32'(exp_dec(OP_CODE_LW, 5'd4, 5'd0)));
        @(posedge clk);
        #1;
        n_in_valid = 1'b0;
        #1;
        check("nohaz.add_valid", 32'(n_out_valid), 32'd1);
        check("nohaz.add_head", 32'(w_obs_n), 32'(exp_dec(OP_CODE_ADD, 5'd2, 5'd7)));
        @(posedge clk);
        #1;
        check("nohaz.empty", 32'(n_out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
